// File: rtl/mul_iter.sv
// mul_iter: iterative shift-add multiplier retiring STEP multiplier bits per
// cycle, with valid/ready handshakes, synchronous kill and optional early-out.
// Operands are converted to magnitudes on accept; the sign is applied once at
// the end, so the same unsigned datapath serves MUL, MULH, MULHSU and MULHU.
module mul_iter #(
  parameter int WIDTH     = 32,
  parameter int STEP      = 2,
  parameter int EARLY_OUT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               kill,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   res,
  output logic [2*WIDTH-1:0] prod,
  output logic               busy
);

  localparam int NSTEPS = WIDTH / STEP;
  localparam int CW     = $clog2(NSTEPS + 1);
  localparam logic [CW-1:0] LAST = CW'(NSTEPS - 1);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  // The multiplicand is kept pre-shifted so each step adds at the right
  // weight without a variable barrel shifter; count only tracks termination.
  logic [2*WIDTH-1:0] mcand_sh;
  logic [WIDTH-1:0]   mplr;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      count;
  logic               neg;
  logic [1:0]         op_q;

  logic               neg_a, neg_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [STEP-1:0]    digit;
  logic [2*WIDTH-1:0] pp;
  logic [2*WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0]   mplr_sh;
  logic               calc_last;
  logic [2*WIDTH-1:0] prod_final;
  logic [WIDTH-1:0]   res_final;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == CALC) || (state == SIGN);

  // Operand magnitudes, per-step partial product and the signed final result.
  always_comb begin
    neg_a      = a[WIDTH-1] & ((op == OP_MULH) || (op == OP_MULHSU));
    neg_b      = b[WIDTH-1] & (op == OP_MULH);
    abs_a      = neg_a ? (~a + 1'b1) : a;
    abs_b      = neg_b ? (~b + 1'b1) : b;
    digit      = mplr[STEP-1:0];
    pp         = mcand_sh * {{(2*WIDTH-STEP){1'b0}}, digit};
    acc_sum    = acc + pp;
    mplr_sh    = mplr >> STEP;
    calc_last  = (count == LAST) || ((EARLY_OUT != 0) && (mplr_sh == '0));
    prod_final = neg ? (~acc + 1'b1) : acc;
    res_final  = (op_q == OP_MUL) ? prod_final[WIDTH-1:0]
                                  : prod_final[2*WIDTH-1:WIDTH];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; kill overrides every transition.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (in_valid)  state_next = CALC;
      CALC: if (calc_last) state_next = SIGN;
      SIGN:                state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default:             state_next = IDLE;
    endcase
    if (kill) state_next = IDLE;
  end

  // Datapath: capture on accept, accumulate in CALC, register result in SIGN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_sh <= '0;
      mplr     <= '0;
      acc      <= '0;
      count    <= '0;
      neg      <= 1'b0;
      op_q     <= 2'b00;
      res      <= '0;
      prod     <= '0;
    end else if (!kill) begin
      unique case (state)
        IDLE: if (in_valid) begin
          mcand_sh <= {{WIDTH{1'b0}}, abs_a};
          mplr     <= abs_b;
          acc      <= '0;
          count    <= '0;
          neg      <= neg_a ^ neg_b;
          op_q     <= op;
        end
        CALC: begin
          acc      <= acc_sum;
          mcand_sh <= mcand_sh << STEP;
          mplr     <= mplr_sh;
          count    <= count + 1'b1;
        end
        SIGN: begin
          prod <= prod_final;
          res  <= res_final;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_iter.sv
// tb_mul_iter: table-driven and scoreboard-checked bench for mul_iter.
// Four instances: default (STEP=2), early-out (STEP=2), STEP=1 and STEP=4.
module tb_mul_iter;

  localparam logic [1:0] MUL    = 2'b00;
  localparam logic [1:0] MULH   = 2'b01;
  localparam logic [1:0] MULHSU = 2'b10;
  localparam logic [1:0] MULHU  = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid_v  [4];
  logic        in_ready_v  [4];
  logic [1:0]  op_v        [4];
  logic [31:0] a_v         [4];
  logic [31:0] b_v         [4];
  logic        kill_v      [4];
  logic        out_valid_v [4];
  logic        out_ready_v [4];
  logic [31:0] res_v       [4];
  logic [63:0] prod_v      [4];
  logic        busy_v      [4];

  mul_iter #(.WIDTH(32), .STEP(2), .EARLY_OUT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .op(op_v[0]), .a(a_v[0]), .b(b_v[0]), .kill(kill_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .res(res_v[0]), .prod(prod_v[0]), .busy(busy_v[0]));

  mul_iter #(.WIDTH(32), .STEP(2), .EARLY_OUT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .op(op_v[1]), .a(a_v[1]), .b(b_v[1]), .kill(kill_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .res(res_v[1]), .prod(prod_v[1]), .busy(busy_v[1]));

  mul_iter #(.WIDTH(32), .STEP(1), .EARLY_OUT(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .op(op_v[2]), .a(a_v[2]), .b(b_v[2]), .kill(kill_v[2]),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .res(res_v[2]), .prod(prod_v[2]), .busy(busy_v[2]));

  mul_iter #(.WIDTH(32), .STEP(4), .EARLY_OUT(0)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
    .op(op_v[3]), .a(a_v[3]), .b(b_v[3]), .kill(kill_v[3]),
    .out_valid(out_valid_v[3]), .out_ready(out_ready_v[3]),
    .res(res_v[3]), .prod(prod_v[3]), .busy(busy_v[3]));

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [63:0] prod;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [63:0] prod;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[11];
  int   checks = 0;
  int   errors = 0;
  int   meas_lat;

  // Reference product computed with plain 64-bit arithmetic on extended operands.
  function automatic logic [63:0] model_prod(input logic [1:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = ((op == MULH) || (op == MULHSU)) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (op == MULH) ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Push the expectation, present one operation to instance d, then wait
  // (bounded) for out_valid while counting latency from the accept cycle.
  task automatic applyStimulus(input int d, input logic [1:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] er, input logic [63:0] ep,
                               input int el);
    exp_t e;
    e.res = er; e.prod = ep; e.lat = el;
    sb_q.push_back(e);
    op_v[d] = op; a_v[d] = a; b_v[d] = b; in_valid_v[d] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[d] = 1'b0;
    a_v[d] = $urandom; b_v[d] = $urandom; op_v[d] = 2'($urandom);
    meas_lat = 1;
    while (!out_valid_v[d] && meas_lat < 200) begin
      @(posedge clk); #1;
      meas_lat++;
    end
  endtask

  // Pop the oldest expectation, compare the held result, then take it.
  task automatic checkOutput(input int d, input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $display("[TB] FAIL %s: scoreboard empty, got result %h, expected none", name, res_v[d]);
      return;
    end
    e = sb_q.pop_front();
    check($sformatf("%s out_valid", name), 64'(out_valid_v[d]), 64'd1);
    check($sformatf("%s res", name), 64'(res_v[d]), 64'(e.res));
    check($sformatf("%s prod", name), prod_v[d], e.prod);
    if (e.lat > 0) check($sformatf("%s latency", name), 64'(meas_lat), 64'(e.lat));
    out_ready_v[d] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[d] = 1'b0;
    check($sformatf("%s in_ready after take", name), 64'(in_ready_v[d]), 64'd1);
    check($sformatf("%s out_valid after take", name), 64'(out_valid_v[d]), 64'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb, rr;
    logic [63:0] rp;
    bit          rose;

    vecs[0]  = '{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 64'hFFFFFFFE00000001};
    vecs[1]  = '{MULH,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 64'h0000000080000000};
    vecs[2]  = '{MUL,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 64'h7FFFFFFF80000000};
    vecs[3]  = '{MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFE};
    vecs[4]  = '{MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 64'h00000006FFFFFFEB};
    vecs[5]  = '{MUL,    32'h00000003, 32'h00000005, 32'h0000000F, 64'h000000000000000F};
    vecs[6]  = '{MULH,   32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFEB};
    vecs[7]  = '{MULHSU, 32'h80000000, 32'h80000000, 32'hC0000000, 64'hC000000000000000};
    vecs[8]  = '{MULH,   32'h80000000, 32'h80000000, 32'h40000000, 64'h4000000000000000};
    vecs[9]  = '{MULHU,  32'h00010000, 32'h00010000, 32'h00000001, 64'h0000000100000000};
    vecs[10] = '{MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 64'h0000000000000001};

    for (int d = 0; d < 4; d++) begin
      in_valid_v[d] = 1'b0; op_v[d] = 2'b00; a_v[d] = '0; b_v[d] = '0;
      kill_v[d] = 1'b0; out_ready_v[d] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 64'(in_ready_v[0]), 64'd1);
    check("reset out_valid", 64'(out_valid_v[0]), 64'd0);
    check("reset busy", 64'(busy_v[0]), 64'd0);
    check("reset res", 64'(res_v[0]), 64'd0);
    check("reset prod", prod_v[0], 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors on the default instance.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].prod, 18);
      checkOutput(0, $sformatf("vec%0d", i));
    end

    // Random operands against the 64-bit reference.
    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(0, 3)); ra = $urandom; rb = $urandom;
      rp = model_prod(rop, ra, rb);
      rr = (rop == MUL) ? rp[31:0] : rp[63:32];
      applyStimulus(0, rop, ra, rb, rr, rp, 18);
      checkOutput(0, $sformatf("rand%0d", i));
    end

    // Backpressure: result held, in_ready low, stray in_valid ignored.
    applyStimulus(0, MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 64'h00000006FFFFFFEB, 18);
    for (int k = 0; k < 10; k++) begin
      in_valid_v[0] = (k == 4);
      op_v[0] = MULHU; a_v[0] = 32'd9; b_v[0] = 32'd9;
      @(posedge clk); #1;
      check($sformatf("bp%0d res", k), 64'(res_v[0]), 64'hFFFFFFEB);
      check($sformatf("bp%0d in_ready", k), 64'(in_ready_v[0]), 64'd0);
      check($sformatf("bp%0d out_valid", k), 64'(out_valid_v[0]), 64'd1);
    end
    in_valid_v[0] = 1'b0;
    checkOutput(0, "bp");
    applyStimulus(0, MUL, 32'd3, 32'd5, 32'd15, 64'd15, 18);
    checkOutput(0, "after_bp");

    // kill in CALC cycle 5.
    op_v[0] = MUL; a_v[0] = 32'd11; b_v[0] = 32'd13; in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    check("killcalc busy", 64'(busy_v[0]), 64'd1);
    repeat (4) begin @(posedge clk); #1; end
    kill_v[0] = 1'b1;
    @(posedge clk); #1;
    kill_v[0] = 1'b0;
    check("killcalc in_ready", 64'(in_ready_v[0]), 64'd1);
    check("killcalc busy after", 64'(busy_v[0]), 64'd0);
    rose = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (out_valid_v[0]) rose = 1'b1;
    end
    check("killcalc out_valid never", 64'(rose), 64'd0);

    // kill in DONE: valid drops, result registers keep their value.
    applyStimulus(0, MUL, 32'd6, 32'd7, 32'd42, 64'd42, 18);
    void'(sb_q.pop_front());
    check("killdone res before", 64'(res_v[0]), 64'd42);
    kill_v[0] = 1'b1;
    @(posedge clk); #1;
    kill_v[0] = 1'b0;
    check("killdone out_valid", 64'(out_valid_v[0]), 64'd0);
    check("killdone in_ready", 64'(in_ready_v[0]), 64'd1);
    check("killdone res kept", 64'(res_v[0]), 64'd42);

    // kill together with in_valid in IDLE: nothing captured.
    op_v[0] = MUL; a_v[0] = 32'd100; b_v[0] = 32'd100;
    in_valid_v[0] = 1'b1; kill_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0; kill_v[0] = 1'b0;
    check("killidle in_ready", 64'(in_ready_v[0]), 64'd1);
    check("killidle busy", 64'(busy_v[0]), 64'd0);
    rose = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (out_valid_v[0]) rose = 1'b1;
    end
    check("killidle out_valid never", 64'(rose), 64'd0);
    applyStimulus(0, MUL, 32'd3, 32'd5, 32'd15, 64'd15, 18);
    checkOutput(0, "after_kill");

    // Asynchronous reset mid-CALC.
    op_v[0] = MULHU; a_v[0] = 32'hFFFFFFFF; b_v[0] = 32'hFFFFFFFF; in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midrst res", 64'(res_v[0]), 64'd0);
    check("midrst prod", prod_v[0], 64'd0);
    check("midrst in_ready", 64'(in_ready_v[0]), 64'd1);
    check("midrst out_valid", 64'(out_valid_v[0]), 64'd0);
    check("midrst busy", 64'(busy_v[0]), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(0, MUL, 32'd3, 32'd5, 32'd15, 64'd15, 18);
    checkOutput(0, "after_rst");

    // Early-out instance.
    applyStimulus(1, MUL, 32'h12345678, 32'd0, 32'd0, 64'd0, 3);
    checkOutput(1, "early b0");
    applyStimulus(1, MUL, 32'd5, 32'd3, 32'd15, 64'd15, 3);
    checkOutput(1, "early b3");
    applyStimulus(1, MULHU, 32'd1, 32'h80000000, 32'd0, 64'h0000000080000000, 18);
    checkOutput(1, "early bmsb");
    applyStimulus(1, MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 64'hFFFFFFFE00000001, 18);
    checkOutput(1, "early full");
    applyStimulus(1, MULHSU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 3);
    checkOutput(1, "early hsu");

    // STEP=1 and STEP=4 instances.
    applyStimulus(2, MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 64'hFFFFFFFE00000001, 34);
    checkOutput(2, "step1 hu");
    applyStimulus(2, MULH, 32'h80000000, 32'hFFFFFFFF, 32'd0, 64'h0000000080000000, 34);
    checkOutput(2, "step1 h");
    applyStimulus(3, MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 64'hFFFFFFFE00000001, 10);
    checkOutput(3, "step4 hu");
    applyStimulus(3, MULH, 32'h80000000, 32'hFFFFFFFF, 32'd0, 64'h0000000080000000, 10);
    checkOutput(3, "step4 h");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_iter.md
# mul_iter

Parametrised iterative multiplier for the execute stage, successor to the fixed-latency 32-bit IP-core multiplier. Pure RTL shift-add engine retiring STEP multiplier bits per cycle, with valid/ready handshakes on both sides, a synchronous kill for pipeline flushes, and optional early termination. Supports all four RV32M-style product selections: MUL, MULH, MULHSU, MULHU.

## Interface

Parameters:
- WIDTH, 32, operand width; must be a multiple of STEP, minimum 8.
- STEP, 2, multiplier bits retired per CALC cycle; legal values 1, 2, 4.
- EARLY_OUT, 0, when 1, CALC ends as soon as the remaining multiplier bits are all zero.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  unit can accept; equals (state == IDLE).
- op  in  2  00 MUL (low half), 01 MULH (s×s high), 10 MULHSU (s×u high), 11 MULHU (u×u high).
- a  in  WIDTH  multiplicand (rs1).
- b  in  WIDTH  multiplier (rs2).
- kill  in  1  synchronous abort of any in-flight or held result.
- out_valid  out  1  res and prod are valid; equals (state == DONE).
- out_ready  in  1  consumer takes the result.
- res  out  WIDTH  selected half of the product.
- prod  out  2*WIDTH  full signed/unsigned product per op.
- busy  out  1  state is CALC or SIGN.

## Operation

- States: IDLE, CALC, SIGN, DONE.
- IDLE, when in_valid is high:
  - Capture a and b.
  - neg_a = a[WIDTH-1] & (op is MULH or MULHSU); neg_b = b[WIDTH-1] & (op is MULH).
  - Store |a| and |b| as WIDTH-bit unsigned magnitudes. The magnitude of the most-negative value is 2^(WIDTH-1), which fits unsigned.
  - Store neg = neg_a ^ neg_b. Clear the accumulator and count. Go to CALC.
- CALC, each cycle:
  - acc += (|a| × mplr[STEP-1:0]) << (count×STEP).
  - mplr >>= STEP; count++.
  - After WIDTH/STEP cycles go to SIGN.
  - With EARLY_OUT=1, go to SIGN on the cycle after the shifted mplr becomes 0. A zero b passes through exactly one CALC cycle.
- SIGN:
  - prod = neg ? -acc : acc, two's complement over 2*WIDTH bits.
  - res = op==MUL ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH].
  - Register both. Go to DONE.
- DONE:
  - Hold res and prod stable while out_valid is high.
  - On out_ready, go to IDLE. A new input is not accepted in the same cycle (in_ready is low in DONE).
- kill:
  - Highest priority. Next state is IDLE from any state; out_valid and busy drop on that edge.
  - res and prod keep their last values.
  - kill together with in_valid in IDLE: the input is not captured.
- Input stability: a, b and op are sampled only at the accept edge; later changes have no effect.
- Arithmetic: the product is exact mod 2^(2*WIDTH) for every op. No overflow flag.

## Timing

- Reset: state IDLE, in_ready=1, out_valid=0, busy=0, res=0, prod=0, internal accumulator and count 0.
- Reset mid-operation aborts immediately (asynchronous); behaviour is identical to a fresh reset.
- Latency from accept edge to first cycle with out_valid=1 is N+2 cycles, where N = number of CALC cycles.
  - Fixed N = WIDTH/STEP when EARLY_OUT=0. Default configuration: 18 cycles.
  - EARLY_OUT=1: N = max(1, ceil(bitlen(|b|)/STEP)).
- Throughput: one operation per N+3 cycles minimum (the DONE cycle with out_ready, then IDLE).
- out_valid holds indefinitely under backpressure. in_ready stays low until the result is taken or killed.

## Test plan

- Default parameters, MULHU, a=0xFFFFFFFF, b=0xFFFFFFFF -> out_valid 18 cycles after accept; prod=0xFFFFFFFE00000001, res=0xFFFFFFFE.
- MULH, a=0x80000000, b=0xFFFFFFFF (−2^31 × −1) -> prod=0x0000000080000000, res=0x00000000. MUL on the same operands -> res=0x80000000.
- MULHSU, a=0xFFFFFFFF (−1), b=0x00000002 -> prod=0xFFFFFFFFFFFFFFFE, res=0xFFFFFFFF. MUL, a=7, b=−3 -> res=0xFFFFFFEB.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> res stable, in_ready=0, an in_valid pulse is ignored. Then out_ready=1 -> IDLE next cycle and the following op is accepted.
- kill asserted in CALC cycle 5, then in DONE, then with in_valid in IDLE -> each goes to IDLE, out_valid never rises, and a following MUL 3×5 returns res=15. rst_n pulsed low mid-CALC gives the full reset values.
- EARLY_OUT=1, STEP=2: b=0 -> latency 3, res=0. b=0x3 -> latency 3. b=0x80000000 -> latency 18. STEP=1 and STEP=4 builds reproduce the results of the first scenario.
